// File: rtl/frame_writer_if.sv
// Pixel-word request bus and SDRAM write bus of the frame writer, grouped as one interface.
// Request handshake: a word transfers on a rising clock when wr_valid && wr_ready; the client holds
// wr_x/wr_y/wr_data stable while wr_valid is high, and wr_ready never depends combinationally on wr_valid.
interface frame_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [15:0] wr_data;

  logic [24:0] sdram_addr;
  logic [15:0] sdram_wdata;
  logic        sdram_wr;
  logic        sdram_ac;

  // Client side: produces pixel words and plays the SDRAM controller.
  modport master (
    output wr_valid, wr_x, wr_y, wr_data,
    input  wr_ready,
    input  sdram_addr, sdram_wdata, sdram_wr,
    output sdram_ac
  );

  // Frame writer side.
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data,
    output wr_ready,
    output sdram_addr, sdram_wdata, sdram_wr,
    input  sdram_ac
  );
endinterface

// File: rtl/frame_writer.sv
// Write side of the double-buffered SDRAM frame buffer: queues pixel words with their back-buffer
// address and issues strobe/ack SDRAM writes whenever the display reader leaves the bus free.
module frame_writer #(
  parameter logic [19:0] ADDR_BUF1  = 20'h9CD20,
  parameter logic [19:0] ADDR_BUF2  = 20'hC2520,
  parameter int          LINE_WORDS = 320,
  parameter int          LINES      = 480,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_flip,
  input  logic           reader_busy,
  input  logic           sdram_wait,
  frame_writer_if.slave  bus,
  output logic           busy,
  output logic           fifo_empty,
  output logic [7:0]     drop_count,
  output logic [1:0]     state_dbg_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [8:0]    X_LIM = 9'(LINE_WORDS);
  localparam logic [8:0]    Y_LIM = 9'(LINES);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [40:0]     mem_q [FIFO_DEPTH];
  logic [24:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [7:0]      drop_q, drop_d;

  logic            accept, in_range, push, pop;
  logic [24:0]     base, req_addr;

  // Address is fixed when the word is accepted, so a later buffer flip cannot retarget queued words.
  assign base     = frame_flip ? {5'd0, ADDR_BUF2} : {5'd0, ADDR_BUF1};
  assign req_addr = base + (25'(bus.wr_y) * 25'(LINE_WORDS)) + 25'(bus.wr_x);
  assign in_range = (bus.wr_x < X_LIM) && (bus.wr_y < Y_LIM);

  assign bus.wr_ready = (count_q != FULL);
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign push         = accept && in_range;
  assign pop          = (state_q == IDLE) && (count_q != '0) && !reader_busy && !sdram_wait;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d           = REQ;
          {addr_d, wdata_d} = mem_q[rd_ptr_q];
        end
      end
      REQ:     if (bus.sdram_ac)  state_d = ACK;
      ACK:     if (!bus.sdram_ac) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: only entries between the cleared pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {req_addr, bus.wr_data};
  end

  assign bus.sdram_wr    = (state_q == REQ);
  assign bus.sdram_addr  = addr_q;
  assign bus.sdram_wdata = wdata_q;
  assign busy            = (state_q != IDLE);
  assign fifo_empty      = (count_q == '0);
  assign drop_count      = drop_q;
  assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: directed scenarios plus random traffic, checked every cycle against a
// queue-based model of pending words, write progress and the drop counter.
module tb_frame_writer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_flip = 1'b0;
  logic       reader_busy = 1'b0;
  logic       sdram_wait = 1'b0;
  logic       busy, fifo_empty;
  logic [7:0] drop_count;
  logic [1:0] state_dbg;

  frame_writer_if bus_if();

  frame_writer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_flip  (frame_flip),
    .reader_busy (reader_busy),
    .sdram_wait  (sdram_wait),
    .bus         (bus_if),
    .busy        (busy),
    .fifo_empty  (fifo_empty),
    .drop_count  (drop_count),
    .state_dbg_o (state_dbg)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [40:0] exp_q[$];
  logic [40:0] m_cur;
  int          m_phase;   // 0 bus free, 1 strobe high, 2 waiting for ack to drop
  int          m_drop;
  bit          m_ready;
  bit          model_on = 0;
  int          n_writes = 0;
  logic        prev_wr = 1'b0;

  function automatic logic [24:0] exp_addr(input bit flip, input int x, input int y);
    int base;
    base = flip ? 'hC2520 : 'h9CD20;
    return 25'(base + y * 320 + x);
  endfunction

  always @(negedge clock) begin
    if (model_on) begin
      check("sdram_wr",    bus_if.sdram_wr, m_phase == 1);
      check("busy",        busy, m_phase != 0);
      check("fifo_empty",  fifo_empty, exp_q.size() == 0);
      check("wr_ready",    bus_if.wr_ready, exp_q.size() != 8);
      check("drop_count",  drop_count, m_drop);
      check("sdram_addr",  bus_if.sdram_addr, m_cur[40:16]);
      check("sdram_wdata", bus_if.sdram_wdata, m_cur[15:0]);
    end
    if (bus_if.sdram_wr === 1'b1 && prev_wr !== 1'b1) n_writes++;
    prev_wr = bus_if.sdram_wr;

    if (reset) begin
      exp_q.delete();
      m_phase  = 0;
      m_cur    = '0;
      m_drop   = 0;
      model_on = 1;
    end else if (model_on) begin
      m_ready = (exp_q.size() != 8);
      case (m_phase)
        0: if (exp_q.size() > 0 && !reader_busy && !sdram_wait) begin
             m_cur   = exp_q.pop_front();
             m_phase = 1;
           end
        1: if (bus_if.sdram_ac) m_phase = 2;
        default: if (!bus_if.sdram_ac) m_phase = 0;
      endcase
      if (bus_if.wr_valid && m_ready) begin
        if (bus_if.wr_x < 320 && bus_if.wr_y < 480)
          exp_q.push_back({exp_addr(frame_flip, int'(bus_if.wr_x), int'(bus_if.wr_y)), bus_if.wr_data});
        else if (m_drop < 255)
          m_drop++;
      end
    end
  end

  // ---------------- SDRAM controller responder ----------------
  int ac_lat  = 1;
  int ac_cnt  = 0;
  bit ac_rand = 0;

  always @(posedge clock) begin
    #1;
    if (reset || bus_if.sdram_wr !== 1'b1) begin
      bus_if.sdram_ac = 1'b0;
      ac_cnt = 0;
      if (ac_rand) ac_lat = $urandom_range(0, 3);
    end else if (!bus_if.sdram_ac) begin
      if (ac_cnt >= ac_lat) bus_if.sdram_ac = 1'b1;
      else ac_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [15:0] d);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_x     = 9'(x);
    bus_if.wr_y     = 9'(y);
    bus_if.wr_data  = d;
    tick();
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic wait_wr(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (bus_if.sdram_wr === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_strobe: no sdram_wr within %0d cycles, required a strobe", lim);
    end
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (busy === 1'b0 && fifo_empty === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b fifo_empty=%b after %0d cycles, required 0/1", busy, fifo_empty, lim);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  int w0;

  initial begin
    bus_if.wr_valid = 1'b0;
    bus_if.wr_x     = '0;
    bus_if.wr_y     = '0;
    bus_if.wr_data  = '0;

    repeat (3) tick();
    @(negedge clock);
    check("rst_wr_ready",   bus_if.wr_ready, 1);
    check("rst_sdram_wr",   bus_if.sdram_wr, 0);
    check("rst_busy",       busy, 0);
    check("rst_addr",       bus_if.sdram_addr, 0);
    check("rst_wdata",      bus_if.sdram_wdata, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_drop",       drop_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // First word: strobe two cycles after acceptance, ack one cycle after the strobe.
    frame_flip = 1'b0;
    ac_lat     = 1;
    push(0, 0, 16'hA1B2);
    tick();
    @(negedge clock);
    check("lat_sdram_wr", bus_if.sdram_wr, 1);
    check("lat_addr",     bus_if.sdram_addr, 32'h0009CD20);
    check("lat_wdata",    bus_if.sdram_wdata, 32'h0000A1B2);
    wait_idle(20);
    check("lat_busy_done", busy, 0);
    tick();

    // Last pixel word of buffer 2.
    frame_flip = 1'b1;
    push(319, 479, 16'(($urandom)));
    wait_wr(10);
    check("corner_addr", bus_if.sdram_addr, 32'h000E7D1F);
    wait_idle(20);
    tick();
    frame_flip = 1'b0;

    // Fill the FIFO while the controller stalls, then drain in order.
    sdram_wait = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_if.wr_valid = 1'b1;
      bus_if.wr_x     = 9'(i * 7);
      bus_if.wr_y     = 9'(i * 11);
      bus_if.wr_data  = 16'($urandom);
      if (i == 7) begin
        @(negedge clock);
        check("fill_ready_7", bus_if.wr_ready, 1);
      end
      if (i == 8) begin
        @(negedge clock);
        check("fill_ready_8", bus_if.wr_ready, 0);
      end
      tick();
    end
    bus_if.wr_valid = 1'b0;
    w0 = n_writes;
    repeat (4) tick();
    sdram_wait = 1'b0;
    wait_idle(100);
    check("fill_drained", n_writes - w0, 8);
    tick();

    // Out-of-range requests only bump the saturating drop counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    w0 = n_writes;
    push(320, 0, 16'h1234);
    repeat (3) tick();
    @(negedge clock);
    check("drop_one",      drop_count, 1);
    check("drop_no_write", n_writes - w0, 0);
    tick();
    push(0, 480, 16'h5678);
    for (int i = 0; i < 298; i++) begin
      bus_if.wr_valid = 1'b1;
      bus_if.wr_x     = 9'($urandom_range(0, 511));
      bus_if.wr_y     = 9'($urandom_range(480, 511));
      bus_if.wr_data  = 16'($urandom);
      tick();
    end
    bus_if.wr_valid = 1'b0;
    @(negedge clock);
    check("drop_sat", drop_count, 255);
    tick();

    // Display reader holding the bus blocks new writes.
    reader_busy = 1'b1;
    push(5, 5, 16'h0F0F);
    repeat (10) tick();
    @(negedge clock);
    check("rb_hold_wr",    bus_if.sdram_wr, 0);
    check("rb_hold_empty", fifo_empty, 0);
    tick();
    reader_busy = 1'b0;
    wait_idle(20);
    tick();

    // Reader grabbing the bus mid-write does not abort it.
    ac_lat = 3;
    push(7, 7, 16'hBEEF);
    wait_wr(10);
    tick();
    reader_busy = 1'b1;
    wait_idle(20);
    check("rb_mid_done_addr", bus_if.sdram_addr, 32'h0009CD20 + 7 * 320 + 7);
    tick();
    reader_busy = 1'b0;

    // Reset during a strobe drops it at once and empties the queue.
    ac_lat = 8;
    push(1, 1, 16'h1111);
    push(2, 2, 16'h2222);
    wait_wr(10);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rst_mid_wr",    bus_if.sdram_wr, 0);
    check("rst_mid_empty", fifo_empty, 1);
    check("rst_mid_ready", bus_if.wr_ready, 1);
    tick();
    reset = 1'b0;
    ac_lat = 1;
    tick();

    // Random traffic with buffer flips, bus contention and variable ack delay.
    ac_rand = 1;
    for (int i = 0; i < 700; i++) begin
      bus_if.wr_valid = ($urandom_range(0, 3) != 0);
      bus_if.wr_x     = 9'($urandom_range(0, 339));
      bus_if.wr_y     = 9'($urandom_range(0, 499));
      bus_if.wr_data  = 16'($urandom);
      if ($urandom_range(0, 31) == 0) frame_flip = ~frame_flip;
      reader_busy = ($urandom_range(0, 5) == 0);
      sdram_wait  = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus_if.wr_valid = 1'b0;
    reader_busy     = 1'b0;
    sdram_wait      = 1'b0;
    wait_idle(200);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
